// File: rtl/fact_pkg.sv
// fact_pkg: shared constants and state encoding for the factorial core
package fact_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int N_MAX = 20;
  localparam int MUL_CYCLES = 8;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/fact_mul8.sv
// fact_mul8: sequential Wx8 shift-add multiplier, LSB first, fixed MUL_CYCLES latency
module fact_mul8 #(
  parameter int W = fact_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [7:0]   b,
  output logic         done,
  output logic [W-1:0] p
);
  import fact_pkg::*;
  logic [W-1:0] mcand, prod;
  logic [7:0] mplier;
  logic [2:0] cnt;
  logic run;
  // p is the product including the current partial, valid on the done cycle
  assign p = prod + (mplier[0] ? mcand : '0);
  assign done = run && cnt == 3'(MUL_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mcand <= '0;
      prod <= '0;
      mplier <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      mcand <= a;
      prod <= '0;
      mplier <= b;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      prod <= p;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 3'd1;
      run <= !done;
    end
endmodule

// File: rtl/factorial_core.sv
// factorial_core: computes n! with a shift-add multiplier and writes it to RAM
module factorial_core #(
  parameter int ADDR_W = fact_pkg::ADDR_W,
  parameter int DATA_W = fact_pkg::DATA_W,
  parameter int N_MAX  = fact_pkg::N_MAX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic [7:0]        op_n,
  input  logic [ADDR_W-1:0] op_addr,
  output logic              op_busy,
  output logic              op_done,
  output logic              op_ovf,
  output logic [DATA_W-1:0] result,
  output logic              m_cen,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din
);
  import fact_pkg::*;
  localparam logic [7:0] NMAX = 8'(N_MAX);
  state_t state;
  logic [7:0] n_q, i;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] acc, mul_a, mul_p;
  logic [7:0] mul_b;
  logic mul_start, mul_done, go_mul;
  // next factor is launched on the same edge the previous one finishes, so MUL is exactly 8 cycles per factor
  assign go_mul = state == S_IDLE && op_start && op_n >= 8'd2 && op_n <= NMAX;
  assign mul_start = go_mul || (state == S_MUL && mul_done && i != n_q);
  assign mul_a = state == S_IDLE ? DATA_W'(1) : mul_p;
  assign mul_b = state == S_IDLE ? 8'd2 : i + 8'd1;
  fact_mul8 #(.W(DATA_W)) u_mul (
    .clk(clk),
    .reset_n(reset_n),
    .start(mul_start),
    .a(mul_a),
    .b(mul_b),
    .done(mul_done),
    .p(mul_p)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      n_q <= '0;
      i <= '0;
      addr_q <= '0;
      acc <= '0;
      op_busy <= 1'b0;
      op_done <= 1'b0;
      op_ovf <= 1'b0;
      result <= '0;
      m_cen <= 1'b0;
      m_wen <= 1'b0;
      m_addr <= '0;
      m_din <= '0;
    end else
      case (state)
        S_IDLE:
          if (op_start) begin
            n_q <= op_n;
            addr_q <= op_addr;
            op_ovf <= op_n > NMAX;
            acc <= DATA_W'(1);
            i <= 8'd2;
            op_busy <= 1'b1;
            if (op_n > NMAX) begin
              state <= S_DONE;
              result <= '0;
              op_done <= 1'b1;
            end else if (op_n < 8'd2) begin
              state <= S_WRITE;
              m_cen <= 1'b1;
              m_wen <= 1'b1;
              m_addr <= op_addr;
              m_din <= DATA_W'(1);
            end else
              state <= S_MUL;
          end
        S_MUL:
          if (mul_done) begin
            acc <= mul_p;
            if (i == n_q) begin
              state <= S_WRITE;
              m_cen <= 1'b1;
              m_wen <= 1'b1;
              m_addr <= addr_q;
              m_din <= mul_p;
            end else
              i <= i + 8'd1;
          end
        S_WRITE: begin
          state <= S_DONE;
          op_done <= 1'b1;
          result <= acc;
          m_cen <= 1'b0;
          m_wen <= 1'b0;
          m_addr <= '0;
          m_din <= '0;
        end
        S_DONE: begin
          state <= S_IDLE;
          op_done <= 1'b0;
          op_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_factorial_core.sv
// tb_factorial_core: directed bench with a cycle-count reference model and a RAM array
module tb_factorial_core;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic op_start = 1'b0;
  logic [7:0] op_n = '0;
  logic [7:0] op_addr = '0;
  logic op_busy, op_done, op_ovf, m_cen, m_wen;
  logic [63:0] result, m_din;
  logic [7:0] m_addr;
  logic [63:0] ram [256];
  int wr_cnt = 0;
  int done_cnt = 0;
  int checks = 0;
  int errors = 0;
  factorial_core dut (
    .clk(clk),
    .reset_n(reset_n),
    .op_start(op_start),
    .op_n(op_n),
    .op_addr(op_addr),
    .op_busy(op_busy),
    .op_done(op_done),
    .op_ovf(op_ovf),
    .result(result),
    .m_cen(m_cen),
    .m_wen(m_wen),
    .m_addr(m_addr),
    .m_din(m_din)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (m_cen && m_wen) begin
      ram[m_addr] <= m_din;
      wr_cnt <= wr_cnt + 1;
    end
    if (op_done) done_cnt <= done_cnt + 1;
  end
  function automatic logic [63:0] fact_of(input logic [7:0] n);
    logic [63:0] f = 64'd1;
    for (int j = 2; j <= int'(n); j++) f = f * 64'(j);
    return f;
  endfunction
  function automatic int lat_of(input logic [7:0] n);
    return n > 8'd20 ? 1 : n < 8'd2 ? 2 : 8 * (int'(n) - 1) + 2;
  endfunction
  // model: k counts cycles since the accepting edge; done at k==lat, write at k==lat-1
  bit m_act = 1'b0;
  bit m_ovf_op = 1'b0;
  bit m_ovf = 1'b0;
  int m_k = 0;
  int m_lat = 0;
  logic [63:0] m_fact = '0;
  logic [63:0] m_res = '0;
  logic [7:0] m_addr_q = '0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_act <= 1'b0;
      m_k <= 0;
      m_ovf <= 1'b0;
      m_res <= '0;
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat && !m_ovf_op) m_res <= m_fact;
      if (m_k + 1 > m_lat) m_act <= 1'b0;
    end else if (op_start) begin
      m_act <= 1'b1;
      m_k <= 1;
      m_addr_q <= op_addr;
      m_ovf_op <= op_n > 8'd20;
      m_ovf <= op_n > 8'd20;
      m_fact <= fact_of(op_n);
      m_lat <= lat_of(op_n);
      if (op_n > 8'd20) m_res <= '0;
    end
  logic e_busy, e_done, e_wr;
  assign e_busy = reset_n && m_act;
  assign e_done = e_busy && m_k == m_lat;
  assign e_wr = e_busy && !m_ovf_op && m_k == m_lat - 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("busy", 64'(op_busy), 64'(e_busy));
    chk("done", 64'(op_done), 64'(e_done));
    chk("ovf", 64'(op_ovf), 64'(reset_n && m_ovf));
    chk("result", result, reset_n ? m_res : 64'd0);
    chk("m_cen", 64'(m_cen), 64'(e_wr));
    chk("m_wen", 64'(m_wen), 64'(e_wr));
    chk("m_addr", 64'(m_addr), e_wr ? 64'(m_addr_q) : 64'd0);
    chk("m_din", m_din, e_wr ? m_fact : 64'd0);
  end
  task automatic run_op(input logic [7:0] n, input logic [7:0] a, input logic [63:0] exp,
                        input int exp_lat, input bit exp_ovf);
    int w0, cyc;
    @(negedge clk);
    w0 = wr_cnt;
    op_start = 1'b1;
    op_n = n;
    op_addr = a;
    @(negedge clk);
    op_start = 1'b0;
    cyc = 1;
    while (!op_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("op_result", result, exp);
    chk("op_ovf", 64'(op_ovf), 64'(exp_ovf));
    @(negedge clk);
    chk("writes", 64'(wr_cnt - w0), exp_ovf ? 64'd0 : 64'd1);
    if (!exp_ovf) chk("ram", ram[a], exp);
  endtask
  initial begin
    int w0, d0, cyc;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(op_busy), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_cen", 64'(m_cen), 64'd0);
    reset_n = 1'b1;
    run_op(8'd5, 8'h03, 64'h78, 34, 1'b0);
    run_op(8'd20, 8'h10, 64'h21C3677C82B40000, 154, 1'b0);
    run_op(8'd0, 8'h01, 64'h1, 2, 1'b0);
    run_op(8'd1, 8'h02, 64'h1, 2, 1'b0);
    run_op(8'd21, 8'h04, 64'h0, 1, 1'b1);
    @(negedge clk);
    w0 = wr_cnt;
    d0 = done_cnt;
    op_start = 1'b1;
    op_n = 8'd10;
    op_addr = 8'h07;
    @(negedge clk);
    op_start = 1'b0;
    repeat (19) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(op_busy), 64'd0);
    chk("abort_done", 64'(op_done), 64'd0);
    chk("abort_cen", 64'(m_cen), 64'd0);
    chk("abort_din", m_din, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_writes", 64'(wr_cnt - w0), 64'd0);
    chk("abort_dones", 64'(done_cnt - d0), 64'd0);
    run_op(8'd3, 8'h09, 64'h6, 18, 1'b0);
    @(negedge clk);
    w0 = wr_cnt;
    d0 = done_cnt;
    op_start = 1'b1;
    op_n = 8'd6;
    op_addr = 8'h05;
    @(negedge clk);
    op_start = 1'b0;
    cyc = 1;
    while (!op_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        op_start = 1'b1;
        op_n = 8'd4;
        op_addr = 8'h06;
      end
      if (cyc == 11) op_start = 1'b0;
    end
    op_start = 1'b1;
    op_n = 8'd4;
    op_addr = 8'h06;
    @(negedge clk);
    op_start = 1'b0;
    chk("busy_latency", 64'(cyc), 64'd42);
    chk("busy_result", result, 64'd720);
    repeat (3) @(negedge clk);
    chk("busy_writes", 64'(wr_cnt - w0), 64'd1);
    chk("busy_dones", 64'(done_cnt - d0), 64'd1);
    chk("busy_ram", ram[5], 64'd720);
    chk("busy_idle", 64'(op_busy), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/factorial_core.md
FACTORIAL_CORE -- requirements
Module: factorial_core

Interface
REQ-001 SHALL have parameters: ADDR_W, 8, RAM address width; DATA_W, 64, RAM data and result width; N_MAX, 20, largest n whose factorial fits DATA_W.
REQ-002 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op_start  input  1  start request, sampled only in IDLE.
REQ-005 op_n  input  8  operand n.
REQ-006 op_addr  input  ADDR_W  RAM word address for the result.
REQ-007 op_busy  output  1  high in every state except IDLE.
REQ-008 op_done  output  1  one-cycle completion pulse.
REQ-009 op_ovf  output  1  n > N_MAX for the last operation; held until the next accepted start.
REQ-010 result  output  DATA_W  last result, held until the next accepted start.
REQ-011 m_cen, m_wen  output  1 each  RAM chip enable and write enable (1 = write).
REQ-012 m_addr  output  ADDR_W  RAM address; m_din  output  DATA_W  RAM write data.

Function
REQ-013 FSM states SHALL be IDLE, MUL, WRITE, DONE.
REQ-014 IDLE with op_start=1 at an edge: latch n and addr; clear op_ovf; set acc=1 and i=2; go to MUL if 2<=n<=N_MAX, WRITE if n<=1, DONE with op_ovf=1 and result=0 if n>N_MAX.
REQ-015 MUL: acc = acc*i via 64x8 shift-add, LSB first, exactly 8 cycles per factor; product taken modulo 2^64.
REQ-016 After the 8th cycle of a factor: if i==n go to WRITE, else i increments and the next factor starts.
REQ-017 WRITE: exactly one cycle with m_cen=1, m_wen=1, m_addr=latched addr, m_din=acc; result<=acc.
REQ-018 DONE: op_done=1 for one cycle, then IDLE.
REQ-019 m_cen, m_wen, m_addr and m_din SHALL be 0 in every state except WRITE.
REQ-020 Latency from the accepting edge to the op_done cycle: 8*(n-1)+2 cycles for n>=2; 2 cycles for n<=1; 1 cycle for overflow.
REQ-021 op_start while busy SHALL be ignored, not queued; op_start in the DONE cycle SHALL also be ignored.
REQ-022 Overflow operations SHALL never drive a RAM write.

Reset
REQ-023 reset_n low SHALL immediately force IDLE and clear all outputs, acc, i, and the multiplier registers to 0.
REQ-024 Reset mid-operation SHALL abort with no RAM write and no op_done pulse.

Structure
REQ-025 Shared package fact_pkg SHALL hold the state encoding, ADDR_W, DATA_W, N_MAX=20 and MUL_CYCLES=8.
REQ-026 SHALL instantiate one sub-module, fact_mul8: a sequential 64x8 shift-add multiplier with start/done handshake and fixed 8-cycle latency.
REQ-027 The bench SHALL connect m_* directly to the existing ram's cen, wen, s_addr and s_din.

Verification
REQ-028 n=5, addr=0x03 -> single write of 0x78 to addr 3; op_done at cycle 34; ram readback of addr 3 = 0x78.
REQ-029 n=20, addr=0x10 -> write 0x21C3677C82B40000; op_done at cycle 154; op_ovf=0.
REQ-030 n=0 and n=1 -> write 0x1; op_done at cycle 2.
REQ-031 n=21 -> op_ovf=1, result=0, no m_cen pulse, op_done at cycle 1.
REQ-032 n=10, then reset_n low at cycle 20 -> all outputs 0, no write; after reset, n=3 completes normally with value 6.
REQ-033 op_start with n=4 asserted during a busy n=6 run -> ignored; only 720 is written, and exactly one op_done pulse.
